// File: rtl/mem_trace_capture_pkg.sv
// Shared widths and the per-lane snapshot record for the memory trace capture block.
// The struct field widths are fixed here, so the top-level width parameters must match them.
package mem_trace_capture_pkg;

    localparam int TRACE_DATA_WIDTH    = 64;
    localparam int TRACE_LOGSIZE_WIDTH = 32;

    typedef struct packed {
        logic                           valid;
        logic [TRACE_DATA_WIDTH-1:0]    address;
        logic                           is_store;
        logic [TRACE_LOGSIZE_WIDTH-1:0] size;
        logic [TRACE_DATA_WIDTH-1:0]    data;
    } trace_lane_t;

endpackage

// File: rtl/mem_trace_snapshot_fifo.sv
// Synchronous FIFO of snapshot entries; head is read straight from storage.
// Latency 1 cycle push-to-head; caller must not push when full unless it pops at the same edge.
module mem_trace_snapshot_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage is deliberately unreset; the empty flag masks stale contents.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    assign head_dat = mem[rd_ptr[AW-1:0]];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/mem_trace_capture.sv
// Snoops per-lane memory requests and buffers one snapshot per firing cycle for a trace logger.
// Latency 1 cycle to outputs; when the buffer is full and not draining, snapshots are dropped and counted.
module mem_trace_capture
    import mem_trace_capture_pkg::*;
#(
    parameter int NUM_LANES     = 4,
    parameter int DEPTH         = 4,
    parameter int DATA_WIDTH    = TRACE_DATA_WIDTH,
    parameter int LOGSIZE_WIDTH = TRACE_LOGSIZE_WIDTH
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_LANES-1:0]               req_valid,
    input  logic [NUM_LANES-1:0]               req_ready,
    input  logic [DATA_WIDTH*NUM_LANES-1:0]    req_address,
    input  logic [NUM_LANES-1:0]               req_is_store,
    input  logic [LOGSIZE_WIDTH*NUM_LANES-1:0] req_size,
    input  logic [DATA_WIDTH*NUM_LANES-1:0]    req_data,
    output logic [NUM_LANES-1:0]               trace_log_valid,
    output logic [DATA_WIDTH*NUM_LANES-1:0]    trace_log_address,
    output logic [NUM_LANES-1:0]               trace_log_is_store,
    output logic [LOGSIZE_WIDTH*NUM_LANES-1:0] trace_log_size,
    output logic [DATA_WIDTH*NUM_LANES-1:0]    trace_log_data,
    input  logic                               trace_log_ready,
    output logic                               overflow,
    output logic [31:0]                        drop_count
);

    trace_lane_t [NUM_LANES-1:0] snap;
    trace_lane_t [NUM_LANES-1:0] head;
    logic [NUM_LANES-1:0]        fire;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        snap_any;
    logic                        push;
    logic                        pop;
    logic                        drop;

    assign fire = req_valid & req_ready;

    always_comb begin
        snap = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (fire[i]) begin
                snap[i].valid    = 1'b1;
                snap[i].address  = req_address[i*DATA_WIDTH +: DATA_WIDTH];
                snap[i].is_store = req_is_store[i];
                snap[i].size     = req_size[i*LOGSIZE_WIDTH +: LOGSIZE_WIDTH];
                if (req_is_store[i]) snap[i].data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign snap_any = |fire;
    assign pop      = !fifo_empty && trace_log_ready;
    assign push     = snap_any && (!fifo_full || pop);
    assign drop     = snap_any && fifo_full && !pop;

    mem_trace_snapshot_fifo #(
        .WIDTH (NUM_LANES * $bits(trace_lane_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_dat (snap),
        .pop      (pop),
        .head_dat (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + 32'd1;
        end
    end

    always_comb begin
        trace_log_valid    = '0;
        trace_log_address  = '0;
        trace_log_is_store = '0;
        trace_log_size     = '0;
        trace_log_data     = '0;
        if (!fifo_empty) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                trace_log_valid[i]                                 = head[i].valid;
                trace_log_address[i*DATA_WIDTH +: DATA_WIDTH]      = head[i].address;
                trace_log_is_store[i]                              = head[i].is_store;
                trace_log_size[i*LOGSIZE_WIDTH +: LOGSIZE_WIDTH]   = head[i].size;
                trace_log_data[i*DATA_WIDTH +: DATA_WIDTH]         = head[i].data;
            end
        end
    end

endmodule

// File: tb/tb_mem_trace_capture.sv
// Randomised and directed bench for mem_trace_capture against a queue-based reference model.
module tb_mem_trace_capture;

    localparam int NL    = 4;
    localparam int DEPTH = 4;
    localparam int DW    = 64;
    localparam int LW    = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic [NL-1:0]     req_valid;
    logic [NL-1:0]     req_ready;
    logic [NL*DW-1:0]  req_address;
    logic [NL-1:0]     req_is_store;
    logic [NL*LW-1:0]  req_size;
    logic [NL*DW-1:0]  req_data;
    logic [NL-1:0]     trace_log_valid;
    logic [NL*DW-1:0]  trace_log_address;
    logic [NL-1:0]     trace_log_is_store;
    logic [NL*LW-1:0]  trace_log_size;
    logic [NL*DW-1:0]  trace_log_data;
    logic              trace_log_ready;
    logic              overflow;
    logic [31:0]       drop_count;

    typedef struct packed {
        logic [NL-1:0]    v;
        logic [NL*DW-1:0] a;
        logic [NL-1:0]    s;
        logic [NL*LW-1:0] z;
        logic [NL*DW-1:0] d;
    } snap_t;

    snap_t       obs;
    snap_t       q[$];
    logic        m_overflow;
    logic [31:0] m_drops;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clock = ~clock;

    always_comb obs = {trace_log_valid, trace_log_address, trace_log_is_store, trace_log_size, trace_log_data};

    mem_trace_capture #(
        .NUM_LANES(NL), .DEPTH(DEPTH), .DATA_WIDTH(DW), .LOGSIZE_WIDTH(LW)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_address        (req_address),
        .req_is_store       (req_is_store),
        .req_size           (req_size),
        .req_data           (req_data),
        .trace_log_valid    (trace_log_valid),
        .trace_log_address  (trace_log_address),
        .trace_log_is_store (trace_log_is_store),
        .trace_log_size     (trace_log_size),
        .trace_log_data     (trace_log_data),
        .trace_log_ready    (trace_log_ready),
        .overflow           (overflow),
        .drop_count         (drop_count)
    );

    // What the logger should see for the current request inputs, straight from the capture rules.
    function automatic snap_t make_snap();
        snap_t s = '0;
        for (int i = 0; i < NL; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                s.v[i]          = 1'b1;
                s.a[i*DW +: DW] = req_address[i*DW +: DW];
                s.s[i]          = req_is_store[i];
                s.z[i*LW +: LW] = req_size[i*LW +: LW];
                if (req_is_store[i]) s.d[i*DW +: DW] = req_data[i*DW +: DW];
            end
        end
        return s;
    endfunction

    function automatic snap_t exp_head();
        if (q.size() == 0) return '0;
        return q[0];
    endfunction

    task automatic drive_lanes(input logic [NL-1:0] v, input logic [NL-1:0] r);
        req_valid = v;
        req_ready = r;
        for (int i = 0; i < NL; i++) begin
            req_address[i*DW +: DW] = {$urandom, $urandom};
            req_is_store[i]         = 1'($urandom_range(0, 1));
            req_size[i*LW +: LW]    = $urandom_range(0, 6);
            req_data[i*DW +: DW]    = {$urandom, $urandom};
        end
    endtask

    // One clock edge: advance the reference queue, then settle just after the edge.
    task automatic tick();
        snap_t s;
        int    occ;
        bit    do_pop;
        @(posedge clock);
        if (!reset) begin
            s      = make_snap();
            occ    = q.size();
            do_pop = (occ > 0) && trace_log_ready;
            if (do_pop) void'(q.pop_front());
            if (s.v != '0) begin
                if (occ < DEPTH || do_pop) q.push_back(s);
                else begin
                    m_overflow = 1'b1;
                    if (m_drops != 32'hFFFF_FFFF) m_drops = m_drops + 32'd1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        trace_log_ready = 1'b1;
        drive_lanes('0, '0);
        q.delete();
        m_overflow = 1'b0;
        m_drops    = '0;
        repeat (2) @(posedge clock);
        #1;
        n_checks++; if (obs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", obs); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_checks++; if (drop_count !== 32'd0) begin n_fail++; $display("FAIL reset_drop_count: got %0d want 0", drop_count); end
        @(negedge clock);
        reset = 1'b0;
        drive_lanes(4'b0001, 4'b0001);
        tick();
        n_checks++; if (trace_log_valid !== 4'b0001) begin n_fail++; $display("FAIL first_push_after_reset: got %b want 0001", trace_log_valid); end
        n_checks++; if (obs !== exp_head()) begin n_fail++; $display("FAIL first_push_fields: got %h want %h", obs, exp_head()); end
        drive_lanes('0, '0);
        tick();
        n_checks++; if (obs !== '0) begin n_fail++; $display("FAIL first_push_drain: got %h want 0", obs); end
    endtask

    task automatic test_single_store();
        trace_log_ready = 1'b1;
        drive_lanes(4'b0100, 4'b1111);
        req_address[2*DW +: DW] = 64'h1000;
        req_is_store[2]         = 1'b1;
        req_size[2*LW +: LW]    = 32'd3;
        req_data[2*DW +: DW]    = 64'hDEAD;
        tick();
        n_checks++; if (trace_log_valid !== 4'b0100) begin n_fail++; $display("FAIL single_store_valid: got %b want 0100", trace_log_valid); end
        n_checks++; if (trace_log_address !== {64'h0, 64'h1000, 128'h0}) begin n_fail++; $display("FAIL single_store_addr: got %h", trace_log_address); end
        n_checks++; if (trace_log_size !== {32'h0, 32'd3, 64'h0}) begin n_fail++; $display("FAIL single_store_size: got %h", trace_log_size); end
        n_checks++; if (trace_log_data !== {64'h0, 64'hDEAD, 128'h0}) begin n_fail++; $display("FAIL single_store_data: got %h", trace_log_data); end
        n_checks++; if (trace_log_is_store !== 4'b0100) begin n_fail++; $display("FAIL single_store_flag: got %b want 0100", trace_log_is_store); end
        drive_lanes('0, '0);
        tick();
        n_checks++; if (obs !== '0) begin n_fail++; $display("FAIL single_store_after: got %h want 0", obs); end
    endtask

    task automatic test_all_load();
        trace_log_ready = 1'b1;
        drive_lanes(4'b1111, 4'b1111);
        req_is_store = '0;
        tick();
        n_checks++; if (trace_log_valid !== 4'b1111) begin n_fail++; $display("FAIL all_load_valid: got %b want 1111", trace_log_valid); end
        n_checks++; if (trace_log_is_store !== 4'b0000) begin n_fail++; $display("FAIL all_load_flag: got %b want 0000", trace_log_is_store); end
        n_checks++; if (trace_log_data !== '0) begin n_fail++; $display("FAIL all_load_data: got %h want 0", trace_log_data); end
        n_checks++; if (obs !== exp_head()) begin n_fail++; $display("FAIL all_load_fields: got %h want %h", obs, exp_head()); end
        drive_lanes('0, '0);
        tick();
    endtask

    task automatic test_backpressure();
        snap_t sent[5];
        trace_log_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_lanes(4'($urandom_range(1, 15)), 4'b1111);
            sent[k] = make_snap();
            tick();
            n_checks++; if (obs !== sent[0]) begin n_fail++; $display("FAIL backpressure_head_%0d: got %h want %h", k, obs, sent[0]); end
        end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL backpressure_overflow: got %b want 1", overflow); end
        n_checks++; if (drop_count !== 32'd1) begin n_fail++; $display("FAIL backpressure_drops: got %0d want 1", drop_count); end
        drive_lanes('0, '0);
        trace_log_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (obs !== sent[k]) begin n_fail++; $display("FAIL backpressure_drain_%0d: got %h want %h", k, obs, sent[k]); end
            tick();
        end
        n_checks++; if (obs !== '0) begin n_fail++; $display("FAIL backpressure_empty: got %h want 0", obs); end
    endtask

    task automatic test_full_push_pop();
        snap_t sent[5];
        trace_log_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_lanes(4'($urandom_range(1, 15)), 4'b1111);
            sent[k] = make_snap();
            tick();
        end
        drive_lanes(4'($urandom_range(1, 15)), 4'b1111);
        sent[4] = make_snap();
        trace_log_ready = 1'b1;
        tick();
        n_checks++; if (drop_count !== 32'd1) begin n_fail++; $display("FAIL full_pushpop_drops: got %0d want 1", drop_count); end
        drive_lanes('0, '0);
        for (int k = 1; k < 5; k++) begin
            n_checks++; if (obs !== sent[k]) begin n_fail++; $display("FAIL full_pushpop_drain_%0d: got %h want %h", k, obs, sent[k]); end
            tick();
        end
        n_checks++; if (obs !== '0) begin n_fail++; $display("FAIL full_pushpop_empty: got %h want 0", obs); end
    endtask

    task automatic test_occupancy_one();
        snap_t b;
        trace_log_ready = 1'b0;
        drive_lanes(4'b0011, 4'b1111);
        tick();
        trace_log_ready = 1'b1;
        drive_lanes(4'b1000, 4'b1111);
        b = make_snap();
        tick();
        n_checks++; if (obs !== b) begin n_fail++; $display("FAIL occ_one_head: got %h want %h", obs, b); end
        drive_lanes('0, '0);
        tick();
        n_checks++; if (obs !== '0) begin n_fail++; $display("FAIL occ_one_empty: got %h want 0", obs); end
    endtask

    task automatic test_fire_gating();
        logic [31:0] drops_before;
        drops_before    = m_drops;
        trace_log_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive_lanes(4'b1111, 4'b0000);
            tick();
            n_checks++; if (obs !== '0) begin n_fail++; $display("FAIL fire_gating_%0d: got %h want 0", k, obs); end
        end
        n_checks++; if (drop_count !== drops_before) begin n_fail++; $display("FAIL fire_gating_drops: got %0d want %0d", drop_count, drops_before); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive_lanes(4'($urandom), 4'($urandom | $urandom));
            trace_log_ready = ($urandom_range(0, 2) != 0);
            tick();
            n_checks++; if (obs !== exp_head()) begin n_fail++; $display("FAIL random_head_%0d: got %h want %h", k, obs, exp_head()); end
            n_checks++; if (overflow !== m_overflow) begin n_fail++; $display("FAIL random_overflow_%0d: got %b want %b", k, overflow, m_overflow); end
            n_checks++; if (drop_count !== m_drops) begin n_fail++; $display("FAIL random_drops_%0d: got %0d want %0d", k, drop_count, m_drops); end
        end
    endtask

    task automatic test_async_reset();
        trace_log_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_lanes(4'($urandom_range(1, 15)), 4'b1111);
            tick();
        end
        drive_lanes('0, '0);
        n_checks++; if (obs !== exp_head() || obs.v == '0) begin n_fail++; $display("FAIL async_reset_pre: got %h want %h", obs, exp_head()); end
        #2;
        reset = 1'b1;
        q.delete();
        m_overflow = 1'b0;
        m_drops    = '0;
        #1;
        n_checks++; if (obs !== '0) begin n_fail++; $display("FAIL async_reset_outputs: got %h want 0", obs); end
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL async_reset_overflow: got %b want 0", overflow); end
        n_checks++; if (drop_count !== 32'd0) begin n_fail++; $display("FAIL async_reset_drops: got %0d want 0", drop_count); end
        trace_log_ready = 1'b1;
        tick();
        n_checks++; if (obs !== '0) begin n_fail++; $display("FAIL async_reset_discard: got %h want 0", obs); end
    endtask

    initial begin
        test_reset();
        test_single_store();
        test_all_load();
        test_backpressure();
        test_full_push_pop();
        test_occupancy_one();
        test_fire_gating();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
